// File: rtl/ustore_loader.sv
// Control-store writer: assembles a byte stream into microcode words, writes them
// from address 0 upward, verifies the trailing checksum and releases the sequencer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no load since reset, sequencer held
// S_LOAD  | accepting word bytes, least significant first
// S_WRITE | one-cycle control-store write strobe
// S_CHECK | accepting the checksum byte
// S_DONE  | load verified, sequencer released
// S_ERROR | checksum mismatch, sequencer held
module ustore_loader #(
    parameter int ADDR_WIDTH     = 13,
    parameter int WORD_WIDTH     = 47,
    parameter int BYTES_PER_WORD = 6
) (
    input  logic                  clock,
    input  logic                  notReset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WORD_WIDTH-1:0] wr_data,
    output logic                  wr_enable,
    output logic                  seq_notReset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int ASM_WIDTH = 8 * BYTES_PER_WORD;
    localparam int IDX_WIDTH = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(BYTES_PER_WORD - 1);
    localparam logic [IDX_WIDTH-1:0]  IDX_ONE   = IDX_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   ADDR_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t                 state;
    logic [ASM_WIDTH-1:0]   asm_reg;
    logic [ASM_WIDTH-1:0]   asm_next;
    logic [IDX_WIDTH-1:0]   byte_idx;
    logic [ADDR_WIDTH:0]    addr;
    logic [ADDR_WIDTH:0]    addr_inc;
    logic [ADDR_WIDTH:0]    count;
    logic [7:0]             sum;
    logic                   take;
    logic                   start_ok;

    assign take     = byte_valid && byte_ready;
    assign start_ok = start && (word_count != '0) && (word_count <= MAX_WORDS);
    // addr is one bit wider than wr_addr so the final increment never wraps
    assign addr_inc = addr + ADDR_ONE;

    always_comb begin
        asm_next = asm_reg;
        asm_next[8*byte_idx +: 8] = byte_data;
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state        <= S_IDLE;
            asm_reg      <= '0;
            byte_idx     <= '0;
            addr         <= '0;
            count        <= '0;
            sum          <= '0;
            byte_ready   <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_enable    <= 1'b0;
            seq_notReset <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    wr_enable <= 1'b0;
                    if (start_ok) begin
                        state        <= S_LOAD;
                        count        <= word_count;
                        addr         <= '0;
                        byte_idx     <= '0;
                        sum          <= '0;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        busy         <= 1'b1;
                        byte_ready   <= 1'b1;
                        seq_notReset <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (take) begin
                        sum <= sum + byte_data;
                        if (byte_idx == LAST_IDX) begin
                            byte_idx   <= '0;
                            byte_ready <= 1'b0;
                            wr_enable  <= 1'b1;
                            wr_addr    <= addr[ADDR_WIDTH-1:0];
                            wr_data    <= asm_next[WORD_WIDTH-1:0];
                            state      <= S_WRITE;
                        end else begin
                            asm_reg  <= asm_next;
                            byte_idx <= byte_idx + IDX_ONE;
                        end
                    end
                end
                S_WRITE: begin
                    wr_enable  <= 1'b0;
                    addr       <= addr_inc;
                    byte_ready <= 1'b1;
                    state      <= (addr_inc == count) ? S_CHECK : S_LOAD;
                end
                S_CHECK: begin
                    if (take) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        if (byte_data == sum) begin
                            done         <= 1'b1;
                            seq_notReset <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            error <= 1'b1;
                            state <= S_ERROR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ustore_loader.sv
// Directed bench for ustore_loader: streams hand-built byte sequences and checks
// control-store writes, completion flags, latency and handshake behaviour.
module tb_ustore_loader;

    logic        clock;
    logic        notReset;
    logic        start;
    logic [13:0] word_count;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [12:0] wr_addr;
    logic [46:0] wr_data;
    logic        wr_enable;
    logic        seq_notReset;
    logic        busy;
    logic        done;
    logic        error;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  stream[$];
    logic [12:0] wq_addr[$];
    logic [46:0] wq_data[$];
    int          cyc;

    ustore_loader dut (
        .clock        (clock),
        .notReset     (notReset),
        .start        (start),
        .word_count   (word_count),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_enable    (wr_enable),
        .seq_notReset (seq_notReset),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (wr_enable === 1'b1) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {58'd0, byte_ready, wr_enable, seq_notReset, busy, done, error}, 64'd0);
        check({tag, "_wr"}, {4'd0, wr_addr, wr_data}, 64'd0);
    endtask

    task automatic make_two(input logic [7:0] cks);
        stream.delete();
        for (int i = 1; i <= 12; i++) stream.push_back(8'(i));
        stream.push_back(cks);
    endtask

    task automatic start_load(input logic [13:0] n);
        wq_addr.delete();
        wq_data.delete();
        word_count = n;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", {62'd0, busy, byte_ready}, 64'd3);
    endtask

    // Pushes stream[] through the handshake; cycles counts clocks from first byte_ready.
    task automatic send(input bit stress, output int cycles);
        int idx;
        int budget;
        bit acc;
        idx = 0;
        cycles = 0;
        budget = stream.size() * 8 + 100;
        while (idx < stream.size() && cycles < budget) begin
            byte_data  = stream[idx];
            byte_valid = stress ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stress) begin
                start = ($urandom_range(0, 3) == 0);
                word_count = 14'd1;
            end
            acc = byte_valid && byte_ready;
            step();
            cycles++;
            if (acc) idx++;
        end
        byte_valid = 1'b0;
        start = 1'b0;
        if (idx < stream.size()) check("send_timeout", 64'(idx), 64'(stream.size()));
    endtask

    task automatic check_two_writes(input string tag);
        check({tag, "_nwrites"}, 64'(wq_addr.size()), 64'd2);
        if (wq_addr.size() >= 2) begin
            check({tag, "_addr0"}, 64'(wq_addr[0]), 64'd0);
            check({tag, "_data0"}, 64'(wq_data[0]), 64'h060504030201);
            check({tag, "_addr1"}, 64'(wq_addr[1]), 64'd1);
            check({tag, "_data1"}, 64'(wq_data[1]), 64'h0C0B0A090807);
        end
    endtask

    task automatic check_result(input string tag, input logic exp_done);
        check({tag, "_result"}, {60'd0, done, error, seq_notReset, busy},
              {60'd0, exp_done, ~exp_done, exp_done, 1'b0});
    endtask

    initial begin
        notReset   = 1'b1;
        start      = 1'b0;
        word_count = '0;
        byte_data  = '0;
        byte_valid = 1'b0;

        // asynchronous reset, asserted and checked mid-cycle
        #2 notReset = 1'b0;
        #1 check_all_zero("reset_async");
        step();
        step();
        notReset = 1'b1;
        step();
        step();
        check_all_zero("reset_idle");

        // out-of-range word counts are ignored
        word_count = 14'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("ign_zero", {62'd0, busy, byte_ready}, 64'd0);
        word_count = 14'd8193;
        start = 1'b1;
        step();
        start = 1'b0;
        check("ign_8193", {62'd0, busy, byte_ready}, 64'd0);

        // two-word load, continuous stream
        make_two(8'h4E);
        start_load(14'd2);
        send(1'b0, cyc);
        check("two_latency", 64'(cyc), 64'd15);
        check_result("two", 1'b1);
        check_two_writes("two");

        word_count = 14'd8193;
        start = 1'b1;
        step();
        start = 1'b0;
        check("ign_in_done", {61'd0, busy, done, seq_notReset}, 64'd3);

        // bits above the word width are dropped
        stream.delete();
        repeat (6) stream.push_back(8'hFF);
        stream.push_back(8'hFA);
        start_load(14'd1);
        check("restart_seq_held", 64'(seq_notReset), 64'd0);
        send(1'b0, cyc);
        check("mask_nwrites", 64'(wq_addr.size()), 64'd1);
        if (wq_addr.size() >= 1) begin
            check("mask_addr", 64'(wq_addr[0]), 64'd0);
            check("mask_data", 64'(wq_data[0]), 64'h7FFFFFFFFFFF);
        end
        check_result("mask", 1'b1);

        // bad checksum, then recovery
        make_two(8'h4F);
        start_load(14'd2);
        send(1'b0, cyc);
        check_two_writes("bad");
        check_result("bad", 1'b0);
        make_two(8'h4E);
        start_load(14'd2);
        send(1'b0, cyc);
        check_two_writes("recover");
        check_result("recover", 1'b1);

        // randomised valid, stray start pulses while busy
        make_two(8'h4E);
        start_load(14'd2);
        send(1'b1, cyc);
        check_two_writes("stress");
        check_result("stress", 1'b1);

        // reset after three bytes aborts the load
        make_two(8'h4E);
        start_load(14'd2);
        stream = stream[0:2];
        send(1'b0, cyc);
        #2 notReset = 1'b0;
        #1 check_all_zero("abort_reset");
        step();
        notReset = 1'b1;
        step();
        step();
        check("abort_nwrites", 64'(wq_addr.size()), 64'd0);
        check_all_zero("abort_idle");
        make_two(8'h4E);
        start_load(14'd2);
        send(1'b0, cyc);
        check_two_writes("after_abort");
        check_result("after_abort", 1'b1);

        // full control store
        stream.delete();
        for (int i = 0; i < 8192 * 6; i++) stream.push_back(8'h00);
        stream.push_back(8'h00);
        start_load(14'd8192);
        send(1'b0, cyc);
        check("full_latency", 64'(cyc), 64'd57345);
        check("full_nwrites", 64'(wq_addr.size()), 64'd8192);
        if (wq_addr.size() == 8192) begin
            check("full_first_addr", 64'(wq_addr[0]), 64'd0);
            check("full_last_addr", 64'(wq_addr[8191]), 64'd8191);
        end
        check_result("full", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ustore_loader.md
Name: ustore_loader

Overview:
- Writer side of the microcode control store: fills a writable control-store RAM that the microsequencer then reads as its microcode ROM.
- Accepts a byte stream over a valid/ready handshake and assembles bytes into control-store words. Each word is written at sequential addresses from 0, then the stream's checksum byte is verified.
- Holds the microsequencer in reset, through seq_notReset, until a load completes with a matching checksum.

Parameters:
- ADDR_WIDTH, 13, control-store address width.
- WORD_WIDTH, 47, control-store word width (control 33 + next-address 13 + select 1).
- BYTES_PER_WORD, 6, bytes per word. Requires 8*BYTES_PER_WORD >= WORD_WIDTH.

Ports:
- clock  in  1  single clock, rising edge.
- notReset  in  1  asynchronous, active-low reset.
- start  in  1  begin a load; sampled only in IDLE, DONE or ERROR.
- word_count  in  ADDR_WIDTH+1  number of words to load, 1..2**ADDR_WIDTH.
- byte_data  in  8  stream byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_addr  out  ADDR_WIDTH  control-store write address.
- wr_data  out  WORD_WIDTH  control-store write data.
- wr_enable  out  1  one-cycle write strobe.
- seq_notReset  out  1  active-low reset to the microsequencer.
- busy  out  1  a load is in progress.
- done  out  1  last load succeeded.
- error  out  1  last load failed its checksum.

Behaviour:
- Reset (notReset=0, asynchronous): state IDLE. All outputs 0, including seq_notReset=0, so the sequencer stays held. Internal address, byte index, word counter and checksum are cleared.
- All outputs are registered. A byte transfers on a rising edge only when byte_valid=1 and byte_ready=1. byte_valid while byte_ready=0 is ignored and the byte is not consumed.
- IDLE/DONE/ERROR: byte_ready=0, busy=0.
  - start=1 with 1 <= word_count <= 2**ADDR_WIDTH: go to LOAD, latch word_count, clear address/index/sum/done/error, set busy=1, drive seq_notReset=0 from the next cycle.
  - start with word_count = 0 or word_count > 2**ADDR_WIDTH is ignored; no state change.
- LOAD: byte_ready=1.
  - Each accepted byte goes to assembly bits [8*i+7:8*i], i = byte index; the first byte is least significant.
  - sum = (sum + byte) mod 256.
  - After byte BYTES_PER_WORD-1: go to WRITE, i=0. Otherwise i++.
- WRITE (exactly one cycle): byte_ready=0, wr_enable=1, wr_addr=current address, wr_data=assembly[WORD_WIDTH-1:0]. Assembly bits above WORD_WIDTH are discarded.
  - Next cycle: address++. If the words written equal word_count, go to CHECK; otherwise go to LOAD.
- wr_addr and wr_data are meaningful only while wr_enable=1. Address never wraps, since word_count is bounded.
- CHECK: byte_ready=1. The accepted byte is compared against sum and is not added to it.
  - Equal: go to DONE with done=1, seq_notReset=1.
  - Not equal: go to ERROR with error=1, seq_notReset=0.
- DONE/ERROR persist until start or reset. A start here restarts a full load from address 0, and seq_notReset falls the cycle after start is sampled.
- start while busy=1 is ignored.
- Latency: byte_ready rises the cycle after start is sampled. With an always-valid stream, a load takes N*(BYTES_PER_WORD+1)+1 cycles from the first byte_ready to DONE/ERROR.
- Reset mid-load aborts immediately. No further wr_enable. Partially written control-store contents are not restored.

Test Plan:
- Reset values: assert notReset=0 mid-cycle -> all outputs 0 immediately. Release it -> state IDLE, outputs stay 0, byte_ready=0.
- Two-word load, continuous stream: word_count=2, stream bytes 0x01..0x0C then checksum 0x4E.
  - wr_enable pulses exactly twice: addr 0 data 47'h060504030201, then addr 1 data 47'h0C0B0A090807.
  - Then done=1, seq_notReset=1, busy=0, 15 cycles from the first byte_ready.
- Top-bit masking: word_count=1, six 0xFF bytes, checksum 0xFA -> wr_data=47'h7FFFFFFFFFFF at addr 0, done=1.
- Bad checksum: repeat the two-word load with checksum 0x4F -> both writes still occur, then error=1, done=0, seq_notReset=0. A following correct load -> done=1, error=0.
- Handshake stress: toggle byte_valid pseudo-randomly, pulse start mid-load, pulse byte_valid in WRITE -> identical writes and result to the two-word load; no byte dropped or duplicated.
- Abort and boundary:
  - start with word_count=0 or 8193 -> ignored.
  - Reset after 3 bytes of a load -> no writes. A restart loads from addr 0 correctly.
  - word_count=8192 -> last write at addr 8191, done=1.
